zmaps_ng: RTL and testbench

ZMAPS_NG -- requirements
Module: zmaps_ng

---
 rtl/zmaps_pkg.sv | 21 ++
 rtl/zmaps_fifo.sv | 58 +++++
 rtl/zmaps_ng.sv | 130 +++++++++++++
 tb/tb_zmaps_ng.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zmaps_pkg.sv
// Shared constants and queue entry layout for the Z80 memory-mapped
// word-file write path.
package zmaps_pkg;

    localparam int CRAM = 0;
    localparam int SFIL = 1;

    localparam logic [3:0] REGS_PAGE_DEF = 4'b0100;

    localparam int FIDX_W  = 2;
    localparam int WADDR_W = 8;
    localparam int WDATA_W = 16;
    localparam int ENTRY_W = FIDX_W + WADDR_W + WDATA_W;

    typedef struct packed {
        logic [FIDX_W-1:0]  f;
        logic [WADDR_W-1:0] wa;
        logic [WDATA_W-1:0] wd;
    } entry_t;

endpackage

// File: rtl/zmaps_fifo.sv
// Small synchronous FIFO with wrapping pointers; push and pop may
// coincide at any fill level, including full.
module zmaps_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];

    assign w_rd = i_pop & ~o_empty;
    // A full queue still takes a word when the head leaves this cycle.
    assign w_wr = i_push & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/zmaps_ng.sv
// Z80 write window into word-wide file RAMs: byte pairs are assembled,
// queued, and merged behind DMA writes, which always win the port.
module zmaps_ng
    import zmaps_pkg::*;
#(
    parameter int         NFILES     = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] REGS_PAGE  = REGS_PAGE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwr_s,
    input  logic [15:0]       a,
    input  logic [7:0]        d,
    input  logic [4:0]        fmaddr,
    input  logic [15:0]       dma_data,
    input  logic [7:0]        dma_wraddr,
    input  logic [NFILES-1:0] dma_file_we,
    output logic [7:0]        zma,
    output logic [15:0]       zmd,
    output logic [NFILES-1:0] file_we,
    output logic              regs_we,
    output logic              zwait,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (NFILES < 1 || NFILES > 4) begin : g_bad_nfiles
        $error("zmaps_ng: NFILES must be 1..4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("zmaps_ng: FIFO_DEPTH must be a power of 2 in 2..16");
    end
    if (int'(REGS_PAGE[3:1]) < NFILES) begin : g_bad_regs
        $error("zmaps_ng: REGS_PAGE overlaps a word file");
    end

    logic             w_hit;
    logic [2:0]       w_f;
    logic             w_fhit;
    logic             w_push;
    logic             w_pop;
    logic             w_dma;
    logic             w_acc;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    entry_t           w_in;
    entry_t           w_head;

    logic [7:0]       r_lo;
    logic             r_ovf;
    logic             r_zwait;

    assign w_hit  = memwr_s & fmaddr[4] & (a[15:12] == fmaddr[3:0]);
    assign w_f    = a[11:9];
    assign w_fhit = w_hit & (w_f < 3'(NFILES));
    assign w_push = w_fhit & a[0];
    assign w_dma  = |dma_file_we;
    assign w_pop  = ~w_dma & ~w_empty & ~rst;
    assign w_acc  = w_push & (~w_full | w_pop);

    assign w_in.f  = w_f[FIDX_W-1:0];
    assign w_in.wa = a[8:1];
    assign w_in.wd = {d, r_lo};

    assign w_cnt_nxt = w_cnt + CNT_W'(w_acc) - CNT_W'(w_pop);

    assign regs_we = ~rst & w_hit & (a[11:8] == REGS_PAGE);
    assign zwait   = r_zwait;
    assign ovf     = r_ovf;

    zmaps_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo    <= '0;
            r_ovf   <= 1'b0;
            r_zwait <= 1'b0;
        end else begin
            if (w_fhit & ~a[0]) begin
                r_lo <= d;
            end
            // A dropped word outranks a clear arriving in the same cycle.
            if (w_push & w_full & ~w_pop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_zwait <= (w_cnt_nxt >= CNT_W'(FIFO_DEPTH - 1));
        end
    end

    always_comb begin
        file_we = '0;
        zma     = '0;
        zmd     = '0;
        if (rst) begin
            file_we = '0;
        end else if (w_dma) begin
            file_we = dma_file_we;
            zma     = dma_wraddr;
            zmd     = dma_data;
        end else if (~w_empty) begin
            for (int i = 0; i < NFILES; i++) begin
                file_we[i] = (w_head.f == FIDX_W'(i));
            end
            zma = w_head.wa;
            zmd = w_head.wd;
        end
    end

endmodule

// File: tb/tb_zmaps_ng.sv
// Directed scenario bench for zmaps_ng with hand-computed expectations.
module tb_zmaps_ng;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwr_s;
    logic [15:0] a;
    logic [7:0]  d;
    logic [4:0]  fmaddr;
    logic [15:0] dma_data;
    logic [7:0]  dma_wraddr;
    logic [1:0]  dma_file_we;
    logic [7:0]  zma;
    logic [15:0] zmd;
    logic [1:0]  file_we;
    logic        regs_we;
    logic        zwait;
    logic        ovf;
    logic        ovf_clr;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    zmaps_ng dut (
        .clk         (clk),
        .rst         (rst),
        .memwr_s     (memwr_s),
        .a           (a),
        .d           (d),
        .fmaddr      (fmaddr),
        .dma_data    (dma_data),
        .dma_wraddr  (dma_wraddr),
        .dma_file_we (dma_file_we),
        .zma         (zma),
        .zmd         (zmd),
        .file_we     (file_we),
        .regs_we     (regs_we),
        .zwait       (zwait),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        memwr_s = 1'b1;
        a       = addr;
        d       = data;
        tick();
        memwr_s = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; memwr_s = 1'b0; a = '0; d = '0;
        fmaddr = 5'h15; ovf_clr = 1'b0;
        dma_data = '0; dma_wraddr = '0; dma_file_we = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (file_we !== 2'b00 || zma !== 8'h00 || zmd !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_out got we=%b zma=%h zmd=%h want 00/00/0000",
                     file_we, zma, zmd);
        end
        n_checks++;
        if (zwait !== 1'b0 || ovf !== 1'b0 || regs_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got zwait=%b ovf=%b regs_we=%b want 0/0/0",
                     zwait, ovf, regs_we);
        end
    endtask

    task automatic test_basic();
        wr(16'h5000, 8'h34);
        memwr_s = 1'b1; a = 16'h5001; d = 8'h12;
        #1;
        n_checks++;
        if (file_we !== 2'b00) begin
            n_err++;
            $display("FAIL basic_strobe_cycle got %b want 00", file_we);
        end
        tick();
        memwr_s = 1'b0;
        #1;
        n_checks++;
        if (file_we !== 2'b01 || zma !== 8'h00 || zmd !== 16'h1234) begin
            n_err++;
            $display("FAIL basic_word got we=%b zma=%h zmd=%h want 01/00/1234",
                     file_we, zma, zmd);
        end
        tick();
        n_checks++;
        if (file_we !== 2'b00 || zmd !== 16'h0000) begin
            n_err++;
            $display("FAIL basic_idle got we=%b zmd=%h want 00/0000", file_we, zmd);
        end
    endtask

    task automatic test_dma_prio();
        wr(16'h5202, 8'hEF);
        dma_file_we = 2'b01; dma_wraddr = 8'h77; dma_data = 16'hAAAA;
        memwr_s = 1'b1; a = 16'h5203; d = 8'hBE;
        #1;
        n_checks++;
        if (file_we !== 2'b01 || zma !== 8'h77) begin
            n_err++;
            $display("FAIL dma_c0 got we=%b zma=%h want 01/77", file_we, zma);
        end
        tick();
        memwr_s = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #1;
            n_checks++;
            if (file_we !== 2'b01 || zmd !== 16'hAAAA) begin
                n_err++;
                $display("FAIL dma_c%0d got we=%b zmd=%h want 01/AAAA",
                         c, file_we, zmd);
            end
            tick();
        end
        dma_file_we = 2'b00;
        #1;
        n_checks++;
        if (file_we !== 2'b10 || zma !== 8'h01 || zmd !== 16'hBEEF) begin
            n_err++;
            $display("FAIL dma_sfil_word got we=%b zma=%h zmd=%h want 10/01/BEEF",
                     file_we, zma, zmd);
        end
        tick();
        n_checks++;
        if (file_we !== 2'b00) begin
            n_err++;
            $display("FAIL dma_after got %b want 00", file_we);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w;
        logic [3:0]  zw_exp;
        zw_exp = 4'b1100;
        dma_file_we = 2'b10; dma_wraddr = 8'h55; dma_data = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            wr(16'h5000 + 16'(2 * k), 8'h10 + 8'(k));
            wr(16'h5001 + 16'(2 * k), 8'hA0 + 8'(k));
            n_checks++;
            if (zwait !== zw_exp[k] || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL ovf_fill%0d got zwait=%b ovf=%b want %b/0",
                         k, zwait, ovf, zw_exp[k]);
            end
        end
        wr(16'h5008, 8'h99);
        ovf_clr = 1'b1;
        wr(16'h5009, 8'h99);
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b1 || zwait !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drop got ovf=%b zwait=%b want 1/1", ovf, zwait);
        end
        dma_file_we = 2'b00;
        #1;
        for (int k = 0; k < 4; k++) begin
            w = {8'hA0 + 8'(k), 8'h10 + 8'(k)};
            n_checks++;
            if (file_we !== 2'b01 || zma !== 8'(k) || zmd !== w) begin
                n_err++;
                $display("FAIL ovf_drain%0d got we=%b zma=%h zmd=%h want 01/%h/%h",
                         k, file_we, zma, zmd, 8'(k), w);
            end
            tick();
        end
        n_checks++;
        if (file_we !== 2'b00 || zwait !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_empty got we=%b zwait=%b want 00/0", file_we, zwait);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear got %b want 0", ovf);
        end
    endtask

    task automatic test_regs_and_misc();
        memwr_s = 1'b1; a = 16'h5400; d = 8'h01;
        #1;
        n_checks++;
        if (regs_we !== 1'b1 || file_we !== 2'b00) begin
            n_err++;
            $display("FAIL regs_hit got regs_we=%b we=%b want 1/00", regs_we, file_we);
        end
        tick();
        fmaddr = 5'h05;
        memwr_s = 1'b1; a = 16'h5400;
        #1;
        n_checks++;
        if (regs_we !== 1'b0) begin
            n_err++;
            $display("FAIL regs_disabled got %b want 0", regs_we);
        end
        tick();
        a = 16'h5001;
        tick();
        memwr_s = 1'b0;
        fmaddr = 5'h15;
        #1;
        n_checks++;
        if (file_we !== 2'b00) begin
            n_err++;
            $display("FAIL window_disabled got %b want 00", file_we);
        end
        wr(16'h5601, 8'h42);
        n_checks++;
        if (file_we !== 2'b00) begin
            n_err++;
            $display("FAIL file_out_of_range got %b want 00", file_we);
        end
        wr(16'h5010, 8'h5A);
        wr(16'h5013, 8'h77);
        n_checks++;
        if (file_we !== 2'b01 || zma !== 8'h09 || zmd !== 16'h775A) begin
            n_err++;
            $display("FAIL lo_word got we=%b zma=%h zmd=%h want 01/09/775A",
                     file_we, zma, zmd);
        end
        wr(16'h5015, 8'h66);
        n_checks++;
        if (file_we !== 2'b01 || zma !== 8'h0A || zmd !== 16'h665A) begin
            n_err++;
            $display("FAIL lo_reuse got we=%b zma=%h zmd=%h want 01/0A/665A",
                     file_we, zma, zmd);
        end
        tick();
    endtask

    task automatic test_reset_flush();
        dma_file_we = 2'b01; dma_wraddr = 8'h33; dma_data = 16'h3333;
        wr(16'h5000, 8'h11);
        wr(16'h5001, 8'h22);
        wr(16'h5003, 8'h44);
        rst = 1'b1;
        memwr_s = 1'b1; a = 16'h5400;
        #1;
        n_checks++;
        if (file_we !== 2'b00 || regs_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_force got we=%b regs_we=%b want 00/0", file_we, regs_we);
        end
        tick();
        rst = 1'b0; memwr_s = 1'b0; dma_file_we = 2'b00;
        #1;
        n_checks++;
        if (file_we !== 2'b00 || zwait !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flush got we=%b zwait=%b ovf=%b want 00/0/0",
                     file_we, zwait, ovf);
        end
        wr(16'h5001, 8'h12);
        n_checks++;
        if (file_we !== 2'b01 || zmd !== 16'h1200) begin
            n_err++;
            $display("FAIL rst_lo_cleared got we=%b zmd=%h want 01/1200", file_we, zmd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dma_prio();
        test_overflow();
        test_regs_and_misc();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
